// File: rtl/sw_array_ctrl.sv
// rtl/sw_array_ctrl.sv - load/stream/drain sequencer for a Smith-Waterman systolic PE chain
module sw_array_ctrl #(
  parameter int NUM_PE    = 16,
  parameter int WIDTH     = 10,
  parameter int REF_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           q_base,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [1:0]           r_base,
  input  logic                 r_valid,
  input  logic                 r_last,
  output logic                 r_ready,
  output logic [1:0]           pe_S,
  output logic                 pe_store_S,
  output logic [1:0]           pe_T,
  output logic                 pe_init,
  input  logic [WIDTH-1:0]     last_V,
  input  logic                 last_init,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     best_score,
  output logic [REF_LEN_W-1:0] best_pos
);

  localparam int CNT_W = $clog2(NUM_PE + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(NUM_PE - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [REF_LEN_W-1:0] REF_ONE  = REF_LEN_W'(1);
  localparam logic [REF_LEN_W-1:0] REF_MAX  = {REF_LEN_W{1'b1}};

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     q_cnt_q, q_cnt_d;
  logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [REF_LEN_W-1:0] r_cnt_q, r_cnt_d;
  logic [REF_LEN_W-1:0] col_cnt_q, col_cnt_d;
  logic [WIDTH-1:0]     best_score_q, best_score_d;
  logic [REF_LEN_W-1:0] best_pos_q, best_pos_d;
  logic                 err_q, err_d;

  logic [REF_LEN_W-1:0] r_cnt_inc;
  logic                 tracking;

  assign r_cnt_inc = r_cnt_q + REF_ONE;
  assign tracking  = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

  // Job sequencing: query load, reference stream with gap/overflow checks, fixed-length drain
  always_comb begin
    state_d     = state_q;
    q_cnt_d     = q_cnt_q;
    drain_cnt_d = drain_cnt_q;
    r_cnt_d     = r_cnt_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          err_d       = 1'b0;
          q_cnt_d     = '0;
          r_cnt_d     = '0;
          drain_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (q_valid) begin
          q_cnt_d = q_cnt_q + CNT_ONE;
          if (q_cnt_q == CNT_LAST) begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (r_valid) begin
          r_cnt_d = r_cnt_inc;
          if (r_last) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = CNT_LAST;
          end else if (r_cnt_inc == REF_MAX) begin
            // Position counter would saturate before the reference ends
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (r_cnt_q != '0) begin
          // A gap after the first beat breaks the diagonal wavefront in the chain
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Best-score tracking on last-PE columns; strict compare keeps the earliest tie
  always_comb begin
    col_cnt_d    = col_cnt_q;
    best_score_d = best_score_q;
    best_pos_d   = best_pos_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        col_cnt_d    = '0;
        best_score_d = '0;
        best_pos_d   = '0;
      end
    end else if (tracking && last_init) begin
      col_cnt_d = col_cnt_q + REF_ONE;
      if ($signed(last_V) > $signed(best_score_q)) begin
        best_score_d = last_V;
        best_pos_d   = col_cnt_q;
      end
    end
  end

  // Handshake and PE-facing drive, decoded from state; data forced to 0 off-beat
  always_comb begin
    q_ready    = (state_q == ST_LOAD);
    r_ready    = (state_q == ST_STREAM);
    pe_store_S = q_ready && q_valid;
    pe_S       = pe_store_S ? q_base : 2'b00;
    pe_init    = r_ready && r_valid;
    pe_T       = pe_init ? r_base : 2'b00;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
  end

  assign err        = err_q;
  assign best_score = best_score_q;
  assign best_pos   = best_pos_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      q_cnt_q      <= '0;
      drain_cnt_q  <= '0;
      r_cnt_q      <= '0;
      col_cnt_q    <= '0;
      best_score_q <= '0;
      best_pos_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_cnt_q      <= q_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      r_cnt_q      <= r_cnt_d;
      col_cnt_q    <= col_cnt_d;
      best_score_q <= best_score_d;
      best_pos_q   <= best_pos_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// tb/tb_sw_array_ctrl.sv - randomized self-checking bench for sw_array_ctrl
module tb_sw_array_ctrl;

  localparam int NUM_PE    = 4;
  localparam int WIDTH     = 10;
  localparam int REF_LEN_W = 16;
  localparam int MAXL      = 16;

  logic clk = 1'b0;
  logic rst, start, q_valid, r_valid, r_last;
  logic last_init = 1'b0;
  logic [1:0] q_base, r_base, pe_S, pe_T;
  logic q_ready, r_ready, pe_store_S, pe_init, busy, done, err;
  logic [WIDTH-1:0] last_V = '0;
  logic [WIDTH-1:0] best_score;
  logic [REF_LEN_W-1:0] best_pos;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  int qry[NUM_PE];
  int refs[MAXL];
  int colv[MAXL];
  logic [1:0] chain[NUM_PE];
  logic hist_v[NUM_PE+1];
  int hist_j[NUM_PE+1];
  int col_in = 0;
  int store_cnt = 0;
  int init_cnt = 0;
  int done_cnt = 0;

  sw_array_ctrl #(.NUM_PE(NUM_PE), .WIDTH(WIDTH), .REF_LEN_W(REF_LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .q_base(q_base), .q_valid(q_valid), .q_ready(q_ready),
    .r_base(r_base), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
    .pe_S(pe_S), .pe_store_S(pe_store_S), .pe_T(pe_T), .pe_init(pe_init),
    .last_V(last_V), .last_init(last_init),
    .busy(busy), .done(done), .err(err),
    .best_score(best_score), .best_pos(best_pos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // PE chain stand-in: query shift register, and last-PE columns delayed NUM_PE cycles
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k <= NUM_PE; k++) begin
        hist_v[k] = 1'b0;
        hist_j[k] = 0;
      end
    end else begin
      for (int k = NUM_PE; k > 0; k--) begin
        hist_v[k] = hist_v[k-1];
        hist_j[k] = hist_j[k-1];
      end
      hist_v[0] = pe_init;
      hist_j[0] = col_in;
      if (pe_init) begin
        col_in++;
        init_cnt++;
      end
      if (pe_store_S) begin
        for (int k = NUM_PE - 1; k > 0; k--) chain[k] = chain[k-1];
        chain[0] = pe_S;
        store_cnt++;
      end
      if (done) done_cnt++;
    end
    if (!pe_store_S) chk("pe_S_zero", 32'(pe_S), 0);
    if (!pe_init) chk("pe_T_zero", 32'(pe_T), 0);
    last_init = hist_v[NUM_PE];
    last_V = (hist_v[NUM_PE] && hist_j[NUM_PE] < MAXL) ? WIDTH'(colv[hist_j[NUM_PE]]) : WIDTH'($urandom);
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Affine-gap local alignment, match +2 mismatch -1 open 2 extend 1; column scores of the last query row
  function automatic void sw_model(input int len);
    int h[NUM_PE+1][MAXL+1];
    int e[NUM_PE+1][MAXL+1];
    int f[NUM_PE+1][MAXL+1];
    for (int i = 0; i <= NUM_PE; i++)
      for (int j = 0; j <= MAXL; j++) begin
        h[i][j] = 0;
        e[i][j] = -1000;
        f[i][j] = -1000;
      end
    for (int i = 1; i <= NUM_PE; i++)
      for (int j = 1; j <= len; j++) begin
        e[i][j] = imax(h[i][j-1] - 2, e[i][j-1] - 1);
        f[i][j] = imax(h[i-1][j] - 2, f[i-1][j] - 1);
        h[i][j] = imax(imax(0, h[i-1][j-1] + ((qry[i-1] == refs[j-1]) ? 2 : -1)), imax(e[i][j], f[i][j]));
      end
    for (int j = 0; j < MAXL; j++) colv[j] = (j < len) ? h[NUM_PE][j+1] : 0;
  endfunction

  function automatic int exp_score(input int len);
    int b = 0;
    for (int j = 0; j < len; j++) if (colv[j] > b) b = colv[j];
    return b;
  endfunction

  function automatic int exp_pos(input int len);
    int b = 0;
    int p = 0;
    for (int j = 0; j < len; j++) if (colv[j] > b) begin
      b = colv[j];
      p = j;
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero();
    chk("z_q_ready", 32'(q_ready), 0);
    chk("z_r_ready", 32'(r_ready), 0);
    chk("z_pe_S", 32'(pe_S), 0);
    chk("z_pe_store_S", 32'(pe_store_S), 0);
    chk("z_pe_T", 32'(pe_T), 0);
    chk("z_pe_init", 32'(pe_init), 0);
    chk("z_busy", 32'(busy), 0);
    chk("z_done", 32'(done), 0);
    chk("z_err", 32'(err), 0);
    chk("z_best_score", 32'(best_score), 0);
    chk("z_best_pos", 32'(best_pos), 0);
  endtask

  task automatic load_query(input logic [15:0] pat, input int pat_len);
    int k = 0;
    int i = 0;
    logic v;
    while (k < NUM_PE && i < 64) begin
      if (pat_len > 0) v = (i < pat_len) ? pat[i] : 1'b1;
      else v = ($urandom_range(0, 9) < 6);
      q_valid = v;
      q_base  = v ? 2'(qry[k]) : 2'($urandom);
      r_valid = 1'($urandom);
      r_last  = 1'($urandom);
      @(negedge clk);
      chk("store_mirror", 32'(pe_store_S), 32'(v));
      if (v) chk("pe_S", 32'(pe_S), 32'(qry[k]));
      chk("q_ready_load", 32'(q_ready), 1);
      chk("pe_init_load", 32'(pe_init), 0);
      chk("busy_load", 32'(busy), 1);
      chk("err_load", 32'(err), 0);
      chk("best_load", 32'(best_score), 0);
      if (v) k++;
      i++;
      tick();
    end
    chk("load_beats", k, NUM_PE);
    if (pat_len > 0) chk("load_cycles", i, pat_len);
    q_valid = 1'b0;
    r_valid = 1'b0;
    r_last  = 1'b0;
  endtask

  task automatic stream_ref(input int len, input int pre_wait, input int cut, output int s);
    int nb;
    nb = (cut > 0) ? cut : len;
    s = -1;
    for (int w = 0; w < pre_wait; w++) begin
      r_valid = 1'b0;
      r_last  = 1'($urandom);
      q_valid = 1'b1;
      q_base  = 2'($urandom);
      @(negedge clk);
      chk("r_ready_wait", 32'(r_ready), 1);
      chk("busy_wait", 32'(busy), 1);
      tick();
    end
    for (int j = 0; j < nb; j++) begin
      r_valid = 1'b1;
      r_base  = 2'(refs[j]);
      r_last  = (j == len - 1);
      q_valid = 1'b1;
      q_base  = 2'($urandom);
      if (j == 0) s = cyc;
      @(negedge clk);
      chk("pe_init", 32'(pe_init), 1);
      chk("pe_T", 32'(pe_T), 32'(refs[j]));
      chk("r_ready", 32'(r_ready), 1);
      chk("q_ready_stream", 32'(q_ready), 0);
      tick();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    q_valid = 1'b0;
  endtask

  task automatic begin_job();
    start = 1'b1;
    col_in = 0;
    store_cnt = 0;
    init_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    tick();
    start = 1'b0;
  endtask

  task automatic run_job(input int len, input logic [15:0] pat, input int pat_len,
                         input int pre_wait, input bit drain_start, input bit use_sw);
    int s, eb, ep, t;
    bit got;
    if (use_sw) sw_model(len);
    eb = exp_score(len);
    ep = exp_pos(len);
    begin_job();
    load_query(pat, pat_len);
    stream_ref(len, pre_wait, 0, s);
    got = 1'b0;
    t = 0;
    while (!got && t < 64) begin
      start = drain_start && (t == 1);
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("done_cycle", cyc - s, len + NUM_PE);
        chk("best_score", 32'(best_score), 32'(eb));
        chk("best_pos", 32'(best_pos), 32'(ep));
      end else begin
        chk("busy_drain", 32'(busy), 1);
      end
      tick();
      t++;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 1);
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (w == 0) begin
        chk("busy_after", 32'(busy), 0);
        chk("done_pulse", 32'(done), 0);
      end
      tick();
    end
    chk("done_count", done_cnt, 1);
    chk("store_count", store_cnt, NUM_PE);
    chk("init_count", init_cnt, len);
    for (int k = 0; k < NUM_PE; k++) chk("pe_contents", 32'(chain[k]), 32'(qry[NUM_PE-1-k]));
    chk("best_hold", 32'(best_score), 32'(eb));
    chk("pos_hold", 32'(best_pos), 32'(ep));
  endtask

  initial begin
    int s;
    rst = 1'b1;
    start = 1'b0;
    q_valid = 1'b0;
    q_base = 2'b00;
    r_valid = 1'b0;
    r_base = 2'b00;
    r_last = 1'b0;
    for (int j = 0; j < MAXL; j++) colv[j] = 0;
    tick();
    tick();
    @(negedge clk);
    chk_all_zero();
    tick();
    rst = 1'b0;
    tick();

    // Basic job: ACGT against ACGT
    for (int k = 0; k < NUM_PE; k++) begin
      qry[k] = k;
      refs[k] = k;
    end
    run_job(4, 16'h0, 0, 0, 1'b0, 1'b1);
    chk("basic_score", 32'(best_score), 8);
    chk("basic_pos", 32'(best_pos), 3);

    // Query bubbles 1,0,1,1,0,1
    run_job(4, 16'b101101, 6, 1, 1'b0, 1'b1);

    // Tie and negative filtering
    colv[0] = 3; colv[1] = 5; colv[2] = 5; colv[3] = -2;
    run_job(4, 16'h0, 0, 0, 1'b0, 1'b0);
    chk("tie_score", 32'(best_score), 5);
    chk("tie_pos", 32'(best_pos), 1);

    // All non-positive scores
    colv[0] = 0; colv[1] = -1; colv[2] = -7; colv[3] = 0; colv[4] = -3;
    run_job(5, 16'h0, 0, 2, 1'b0, 1'b0);

    // Reference stall after two beats
    for (int j = 0; j < MAXL; j++) refs[j] = $urandom_range(0, 3);
    sw_model(8);
    begin_job();
    load_query(16'h0, 0);
    stream_ref(8, 1, 2, s);
    @(negedge clk);
    chk("busy_stall", 32'(busy), 1);
    tick();
    @(negedge clk);
    chk("err_set", 32'(err), 1);
    chk("busy_err", 32'(busy), 0);
    for (int w = 0; w < 10; w++) tick();
    chk("no_done_err", done_cnt, 0);
    chk("err_sticky", 32'(err), 1);
    begin_job();
    @(negedge clk);
    chk("err_cleared", 32'(err), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-STREAM, then a full job
    for (int k = 0; k < NUM_PE; k++) qry[k] = $urandom_range(0, 3);
    for (int j = 0; j < MAXL; j++) refs[j] = qry[j % NUM_PE];
    sw_model(10);
    begin_job();
    load_query(16'h0, 0);
    stream_ref(10, 0, 7, s);
    rst = 1'b1;
    r_valid = 1'b1;
    q_valid = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero();
    tick();
    r_valid = 1'b0;
    q_valid = 1'b0;
    tick();
    run_job(6, 16'h0, 0, 0, 1'b0, 1'b1);

    // Start pulse during DRAIN
    for (int k = 0; k < NUM_PE; k++) begin
      qry[k] = k;
      refs[k] = k;
    end
    run_job(4, 16'h0, 0, 0, 1'b1, 1'b1);

    // Randomized jobs
    for (int n = 0; n < 14; n++) begin
      for (int k = 0; k < NUM_PE; k++) qry[k] = $urandom_range(0, 3);
      for (int j = 0; j < MAXL; j++)
        refs[j] = ($urandom_range(0, 1) == 1) ? qry[j % NUM_PE] : $urandom_range(0, 3);
      run_job($urandom_range(1, 12), 16'h0, 0, $urandom_range(0, 2), 1'($urandom), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sw_array_ctrl.md
# sw_array_ctrl

Sequencer for a linear systolic chain of `NUM_PE` Smith-Waterman affine-gap PEs. It loads the query sequence into the chain through the store_S shift path and streams one reference sequence through the T/init path. It then drains the pipeline while tracking the best score emitted by the last PE, and reports that score with its reference position. It sits between the host-side query and reference streams and PE 0 of the array; it also observes the outputs of the last PE.

## Interface
Parameters:
- `NUM_PE`, 16, number of PEs in the chain (≥2).
- `WIDTH`, 10, score width; matches PE `WIDTH`.
- `REF_LEN_W`, 16, width of the reference position counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin job; sampled only in IDLE.
- `q_base`  in  2  query base.
- `q_valid`  in  1  query base valid.
- `q_ready`  out  1  query base accepted when `q_valid&&q_ready`.
- `r_base`  in  2  reference base.
- `r_valid`  in  1  reference base valid.
- `r_last`  in  1  marks the final reference base.
- `r_ready`  out  1  reference accept.
- `pe_S`  out  2  to PE0 `S_in`.
- `pe_store_S`  out  1  to PE0 `store_S_in`.
- `pe_T`  out  2  to PE0 `T_in`.
- `pe_init`  out  1  to PE0 `init_in`.
- `last_V`  in  WIDTH  `V_out` of PE `NUM_PE-1`, signed.
- `last_init`  in  1  `init_out` of PE `NUM_PE-1`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky protocol error; cleared by the next accepted `start`.
- `best_score`  out  WIDTH  maximum `last_V` of the job.
- `best_pos`  out  REF_LEN_W  0-based reference index of `best_score`.

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- **IDLE.** On `start`: clear `err`, clear `best_score` and `best_pos` to 0, clear all counters, go to LOAD.
- **LOAD.** `q_ready`=1.
  - `pe_store_S = q_valid`, `pe_S = q_base`; `pe_S`=0 when no beat is accepted.
  - Bubbles are allowed; the chain shift tolerates gaps.
  - After exactly `NUM_PE` accepted beats, go to STREAM. The first query base fed ends in PE `NUM_PE-1`; the last ends in PE 0.
- **STREAM.** `r_ready`=1.
  - `pe_T = r_base`, `pe_init = r_valid` (`pe_T`=0 when `pe_init`=0).
  - Before the first beat, `r_valid`=0 is a wait.
  - After the first beat, `r_valid`=0 before `r_last` is an error: set `err`, go to IDLE, no `done`.
  - Reference beat counter reaching 2^`REF_LEN_W`−1 without `r_last` is also an error.
  - A beat with `r_last` goes to DRAIN.
- **DRAIN.** Lasts exactly `NUM_PE` cycles (down-counter), then go to DONE.
- **DONE.** `done`=1 for one cycle, then go to IDLE.
- **Score tracking** runs in STREAM and DRAIN.
  - A column counter increments on each cycle with `last_init`=1.
  - On such a cycle, if `$signed(last_V) > $signed(best_score)`, then `best_score <= last_V` and `best_pos <= column counter`.
  - Ties keep the earliest position; all-zero scores give 0/0.
- `best_score` and `best_pos` hold after `done` until the next `start`.
- All PE-facing outputs are 0 in IDLE, DRAIN and DONE.

## Timing
- Reset: state IDLE. All outputs are 0: `q_ready`, `r_ready`, `pe_*`, `busy`, `done`, `err`, `best_score`, `best_pos`.
- A reset mid-job aborts immediately with no `done`. The PE chain is reset by the same `rst`.
- `start` → LOAD on the next cycle; `busy` rises in that cycle.
- The STREAM entry cycle can accept a reference beat, the cycle after the last query beat. The PE S value is final before its T arrives.
- With the first reference beat in cycle s, the score for reference j appears on `last_V`/`last_init` in cycle s+j+`NUM_PE`.
- For an L-beat reference, the final score arrives in the last DRAIN cycle, and `best_*` is valid in the DONE cycle. Total: s+L+`NUM_PE` is the DONE cycle.
- `start` asserted outside IDLE is ignored.
- `q_valid`, `r_valid` and `r_last` are ignored outside their states. `q_ready` and `r_ready` are combinational from state only.

## Test plan
All scenarios use `NUM_PE`=4.
- **Basic job.** Query A,C,G,T with no gaps, then reference A,C,G,T with `last_init`/`last_V` modelled by a PE chain.
  - `pe_store_S` is high for 4 cycles and `pe_init` for 4 cycles.
  - `done` occurs exactly 4+4 cycles after the first reference beat's cycle+0 (DONE cycle = s+8).
  - `best_score` = 8, `best_pos` = 3.
- **Query bubbles.** `q_valid` pattern 1,0,1,1,0,1 → `pe_store_S` mirrors `q_valid` and the state leaves LOAD after the 6th cycle. PE contents are the same as for the gap-free load.
- **Reference stall error.** `r_valid` drops after 2 beats without `r_last` → `err`=1, state IDLE, no `done`. The next `start` clears `err`.
- **Tie and negative filtering.** Drive `last_init`=1 with `last_V` = 3, 5, 5, −2 (two's complement) → `best_score`=5, `best_pos`=1.
- **Reset mid-STREAM.** Assert `rst` → next cycle all outputs are 0 and the state is IDLE. A subsequent full job completes correctly.
- **Start while busy.** A `start` pulse in DRAIN is ignored: exactly one `done`, and best values are unchanged.
